// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: sequencing controller for the 5-stage core.
// Generates load enables and clear-to-bubble flushes for the PC and the
// IF/ID, ID/EX, EX/MEM, MEM/WB registers. Resolves load-use hazards,
// taken-branch redirects, data-memory wait states (with timeout) and debug
// halt, and counts cycles in which the PC is held.
module pipeline_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255  // 1..65535 MEMWAIT cycles
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  idRs1,
    input  logic [4:0]  idRs2,
    input  logic        idUsesRs1,
    input  logic        idUsesRs2,
    input  logic [4:0]  exRd,
    input  logic        exMemRead,
    input  logic        exBranchTaken,
    input  logic        memReq,
    input  logic        memReady,
    input  logic        haltReq,
    output logic        pcEn,
    output logic        ifidEn,
    output logic        idexEn,
    output logic        exmemEn,
    output logic        memwbEn,
    output logic        ifidFlush,
    output logic        idexFlush,
    output logic        exmemFlush,
    output logic        memwbFlush,
    output logic        halted,
    output logic        busError,
    output logic [31:0] stallCycles
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALT    = 2'd2
    } state_e;

    // Per-register load enables, MSB = PC side of the pipe.
    typedef struct packed {
        logic pc;
        logic ifid;
        logic idex;
        logic exmem;
        logic memwb;
    } en_t;

    // Clear-to-bubble controls; the PC has no flush.
    typedef struct packed {
        logic ifid;
        logic idex;
        logic exmem;
        logic memwb;
    } flush_t;

    localparam logic [16:0] TIMEOUT_L = 17'(MEM_TIMEOUT);
    localparam en_t    EN_ALL   = 5'b11111;
    localparam en_t    EN_NONE  = 5'b00000;
    // Memory wait: everything upstream of MEM holds; MEM/WB gets a bubble
    // so the instruction in WB is not written back twice.
    localparam en_t    EN_MWAIT = 5'b00001;
    localparam flush_t FL_NONE  = 4'b0000;

    state_e      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] stall_q;

    en_t         en;
    flush_t      fl;

    logic        load_use;
    logic        mem_stall;
    logic [16:0] wait_next;
    logic        wait_timeout;

    // Hazard and wait detection from the current stage contents.
    always_comb begin
        load_use  = exMemRead && (exRd != 5'd0) &&
                    ((idUsesRs1 && (idRs1 == exRd)) ||
                     (idUsesRs2 && (idRs2 == exRd)));
        mem_stall = memReq && !memReady;
        // Counter value after this MEMWAIT cycle; timeout when it reaches the limit.
        wait_next    = {1'b0, wait_cnt_q} + 17'd1;
        wait_timeout = (wait_next == TIMEOUT_L);
    end

    // Next-state and Mealy output logic; priority in RUN is wait > branch > load-use.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        bus_err_d  = bus_err_q;
        en         = EN_NONE;
        fl         = FL_NONE;
        halted     = 1'b0;

        if (rst) begin
            state_d    = RUN;
            wait_cnt_d = 16'd0;
            bus_err_d  = 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    en = EN_ALL;
                    if (mem_stall) begin
                        // EX is frozen, so branch / load-use get another look later.
                        en         = EN_MWAIT;
                        fl.memwb   = 1'b1;
                        state_d    = MEMWAIT;
                        wait_cnt_d = 16'd0;
                    end else begin
                        if (exBranchTaken) begin
                            // The ID instruction is on the wrong path, so any
                            // load-use stall on it is moot; PC takes the target.
                            fl.ifid = 1'b1;
                            fl.idex = 1'b1;
                        end else if (load_use) begin
                            en.pc   = 1'b0;
                            en.ifid = 1'b0;
                            fl.idex = 1'b1;
                        end
                        if (haltReq) begin
                            state_d = HALT;
                        end
                    end
                end

                MEMWAIT: begin
                    en         = EN_MWAIT;
                    fl.memwb   = 1'b1;
                    wait_cnt_d = wait_next[15:0];
                    if (memReady) begin
                        // Access completes this cycle; let it write back.
                        en       = EN_ALL;
                        fl.memwb = 1'b0;
                        state_d  = RUN;
                    end else if (!memReq) begin
                        // Request vanished without completion: recover to RUN.
                        state_d = RUN;
                    end else if (wait_timeout) begin
                        // Abandon the access and let the pipe move on.
                        en        = EN_ALL;
                        fl.memwb  = 1'b0;
                        bus_err_d = 1'b1;
                        state_d   = RUN;
                    end
                end

                HALT: begin
                    halted = 1'b1;
                    if (!haltReq) begin
                        state_d = RUN;
                    end
                end

                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // State, wait counter and sticky bus error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= 16'd0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // Stall-cycle counter: counts cycles with the PC held, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 32'd0;
        end else if (!en.pc) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign pcEn        = en.pc;
    assign ifidEn      = en.ifid;
    assign idexEn      = en.idex;
    assign exmemEn     = en.exmem;
    assign memwbEn     = en.memwb;
    assign ifidFlush   = fl.ifid;
    assign idexFlush   = fl.idex;
    assign exmemFlush  = fl.exmem;
    assign memwbFlush  = fl.memwb;
    assign busError    = bus_err_q;
    assign stallCycles = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl (MEM_TIMEOUT=4). Stimulus applies one
// directed vector per cycle and queues the hand-computed expected outputs;
// the monitor pops and compares on the falling edge.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  idRs1, idRs2, exRd;
    logic        idUsesRs1, idUsesRs2, exMemRead, exBranchTaken;
    logic        memReq, memReady, haltReq;
    logic        pcEn, ifidEn, idexEn, exmemEn, memwbEn;
    logic        ifidFlush, idexFlush, exmemFlush, memwbFlush;
    logic        halted, busError;
    logic [31:0] stallCycles;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       nm;
        logic [10:0] o;
        logic [31:0] sc;
    } exp_t;

    exp_t sb[$];

    // {pcEn,ifidEn,idexEn,exmemEn,memwbEn, ifidF,idexF,exmemF,memwbF, halted,busError}
    localparam logic [10:0] E_RST  = 11'b00000_0000_00;
    localparam logic [10:0] E_RUN  = 11'b11111_0000_00;
    localparam logic [10:0] E_LU   = 11'b00111_0100_00;
    localparam logic [10:0] E_BR   = 11'b11111_1100_00;
    localparam logic [10:0] E_MW   = 11'b00001_0001_00;
    localparam logic [10:0] E_HALT = 11'b00000_0000_10;
    localparam logic [10:0] BE     = 11'b00000_0000_01;

    pipeline_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .idRs1(idRs1), .idRs2(idRs2),
        .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2),
        .exRd(exRd), .exMemRead(exMemRead), .exBranchTaken(exBranchTaken),
        .memReq(memReq), .memReady(memReady), .haltReq(haltReq),
        .pcEn(pcEn), .ifidEn(ifidEn), .idexEn(idexEn),
        .exmemEn(exmemEn), .memwbEn(memwbEn),
        .ifidFlush(ifidFlush), .idexFlush(idexFlush),
        .exmemFlush(exmemFlush), .memwbFlush(memwbFlush),
        .halted(halted), .busError(busError), .stallCycles(stallCycles)
    );

    always #5 clk = ~clk;

    task automatic idle();
        rst = 1'b0; idRs1 = 5'd0; idRs2 = 5'd0; exRd = 5'd0;
        idUsesRs1 = 1'b0; idUsesRs2 = 1'b0; exMemRead = 1'b0;
        exBranchTaken = 1'b0; memReq = 1'b0; memReady = 1'b0; haltReq = 1'b0;
    endtask

    // Queue expectation for the vector currently on the inputs, then advance.
    task automatic tick(input string nm, input logic [10:0] o, input logic [31:0] sc);
        exp_t e;
        e.nm = nm; e.o = o; e.sc = sc;
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    // Monitor: outputs are presented every cycle; compare at the falling edge.
    initial begin
        exp_t e;
        logic [10:0] act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                act = {pcEn, ifidEn, idexEn, exmemEn, memwbEn,
                       ifidFlush, idexFlush, exmemFlush, memwbFlush, halted, busError};
                checks++;
                if (act !== e.o) begin
                    errors++;
                    $display("FAIL %s ctrl: got %b want %b", e.nm, act, e.o);
                end
                checks++;
                if (stallCycles !== e.sc) begin
                    errors++;
                    $display("FAIL %s stallCycles: got %0d want %0d", e.nm, stallCycles, e.sc);
                end
            end
        end
    end

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        tick("reset0", E_RST, 0);
        tick("reset1", E_RST, 0);
        idle();
        tick("first_run", E_RUN, 0);
        // load-use on rs1
        exMemRead = 1; exRd = 5; idRs1 = 5; idUsesRs1 = 1;
        tick("lu_rs1", E_LU, 0);
        idle();
        tick("after_lu", E_RUN, 1);
        // exRd = x0 never stalls
        exMemRead = 1; exRd = 0; idRs1 = 0; idUsesRs1 = 1;
        tick("lu_x0", E_RUN, 1);
        idle();
        // load-use on rs2
        exMemRead = 1; exRd = 7; idRs2 = 7; idUsesRs2 = 1;
        tick("lu_rs2", E_LU, 1);
        idle();
        // register matches but not used
        exMemRead = 1; exRd = 9; idRs1 = 9; idUsesRs1 = 0;
        tick("lu_unused", E_RUN, 2);
        idle();
        // branch beats load-use
        exMemRead = 1; exRd = 5; idRs1 = 5; idUsesRs1 = 1; exBranchTaken = 1;
        tick("br_lu", E_BR, 2);
        idle();
        tick("after_br", E_RUN, 2);
        // memory wait, ready low 3 cycles
        memReq = 1; memReady = 0;
        tick("mw_enter", E_MW, 2);
        tick("mw_1", E_MW, 3);
        tick("mw_2", E_MW, 4);
        memReady = 1;
        tick("mw_done", E_RUN, 5);
        idle();
        tick("mw_after", E_RUN, 5);
        // halt requested during a wait is deferred
        memReq = 1; memReady = 0; haltReq = 1;
        tick("hw_enter", E_MW, 5);
        tick("hw_1", E_MW, 6);
        memReady = 1;
        tick("hw_done", E_RUN, 7);
        memReq = 0; memReady = 0;
        tick("halt_decide", E_RUN, 7);
        tick("halted", E_HALT, 7);
        haltReq = 0;
        tick("halt_release", E_HALT, 8);
        tick("halt_left", E_RUN, 9);
        // timeout with MEM_TIMEOUT=4
        memReq = 1; memReady = 0;
        tick("to_enter", E_MW, 9);
        tick("to_1", E_MW, 10);
        tick("to_2", E_MW, 11);
        tick("to_3", E_MW, 12);
        tick("to_4", E_RUN, 13);
        idle();
        tick("to_after", E_RUN | BE, 13);
        exBranchTaken = 1;
        tick("to_sticky_br", E_BR | BE, 13);
        idle();
        haltReq = 1;
        tick("pre_halt", E_RUN | BE, 13);
        tick("halt_be", E_HALT | BE, 13);
        // reset mid-halt
        rst = 1;
        tick("rst_halt", E_RST | BE, 14);
        idle();
        tick("rst_clear", E_RUN, 0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
